// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: dm_* access-size encoding, byte-enable width
// and the lane aligner used by the store buffer (and reusable by the load path).
package store_unit_pkg;

  localparam logic [2:0] dm_word              = 3'd0;
  localparam logic [2:0] dm_halfword          = 3'd1;
  localparam logic [2:0] dm_halfword_unsigned = 3'd2;
  localparam logic [2:0] dm_byte              = 3'd3;
  localparam logic [2:0] dm_byte_unsigned     = 3'd4;

  localparam int BE_W = 4;

  typedef struct packed {
    logic [31:0]     wdata;
    logic [BE_W-1:0] be;
    logic            err;
  } align_t;

  // Replicate the narrow operand across every lane; the enables select the real one.
  function automatic align_t align_store(input logic [2:0]  dm,
                                         input logic [1:0]  bias,
                                         input logic [31:0] data);
    align_t r;
    r = '0;
    case (dm)
      dm_word: begin
        r.wdata = data;
        r.be    = 4'b1111;
        r.err   = (bias != 2'd0);
      end
      dm_halfword, dm_halfword_unsigned: begin
        r.wdata = {2{data[15:0]}};
        r.be    = 4'b0011 << bias;
        r.err   = bias[0];
      end
      dm_byte, dm_byte_unsigned: begin
        r.wdata = {4{data[7:0]}};
        r.be    = 4'b0001 << bias;
        r.err   = 1'b0;
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational dm_ctrl + address bias to lane-aligned write data, byte
// enables and a misaligned/illegal flag.
module store_align
  import store_unit_pkg::*;
(
  input  logic [2:0]      i_dm_ctrl,
  input  logic [1:0]      i_bias,
  input  logic [31:0]     i_data,
  output logic [31:0]     o_wdata,
  output logic [BE_W-1:0] o_be,
  output logic            o_err
);

  align_t w_res;

  assign w_res   = align_store(i_dm_ctrl, i_bias, i_data);
  assign o_wdata = w_res.wdata;
  assign o_be    = w_res.be;
  assign o_err   = w_res.err;

endmodule

// File: rtl/store_unit.sv
// Store buffer: aligns MEM-stage stores into byte lanes, queues them in a
// small FIFO, drains to data memory and flags loads that hit a pending word.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        dm_ctrl,
  output logic              st_ready,
  output logic              st_err,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]     w_wdata;
  logic [BE_W-1:0] w_be;
  logic            w_err;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_hazard;
  logic            w_unused_ld;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [WA_W-1:0]  r_addr  [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic [BE_W-1:0]  r_be    [DEPTH];

  store_align u_align (
    .i_dm_ctrl (dm_ctrl),
    .i_bias    (st_addr[1:0]),
    .i_data    (st_data),
    .o_wdata   (w_wdata),
    .o_be      (w_be),
    .o_err     (w_err)
  );

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign st_ready = ~w_full;
  assign st_err   = st_valid & w_err;
  // No full-buffer bypass: a same-cycle pop does not free a slot for this push.
  assign w_push   = st_valid & ~w_full & ~w_err;
  assign w_pop    = ~w_empty & mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]  <= st_addr[ADDR_W-1:2];
      r_wdata[r_wr_ptr] <= w_wdata;
      r_be[r_wr_ptr]    <= w_be;
    end
  end

  // Head fields are zeroed while empty so stale storage never reaches the bus.
  assign mem_we    = ~w_empty;
  assign empty     = w_empty;
  assign mem_addr  = w_empty ? '0 : {r_addr[r_rd_ptr], 2'b00};
  assign mem_wdata = w_empty ? '0 : r_wdata[r_rd_ptr];
  assign mem_be    = w_empty ? '0 : r_be[r_rd_ptr];

  // An entry is live when its distance from the head is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, off} < r_count) && (r_addr[i] == ld_addr[ADDR_W-1:2]))
        w_hazard = 1'b1;
    end
  end

  assign ld_hazard   = ld_valid & w_hazard;
  assign w_unused_ld = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a queue-based reference model checked on
// every falling edge, plus literal expectations for the listed scenarios.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  dm_ctrl = '0;
  logic        st_ready, st_err;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  store_unit #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .dm_ctrl(dm_ctrl),
    .st_ready(st_ready), .st_err(st_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Access size in bytes; 0 means illegal encoding.
  function automatic int size_of(input logic [2:0] dm);
    case (dm)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic void model_align(input logic [2:0] dm, input logic [31:0] a,
                                      input logic [31:0] d, output logic bad,
                                      output logic [31:0] wd, output logic [3:0] be);
    int sz, lo;
    sz = size_of(dm);
    lo = int'(a % 4);
    wd = '0;
    be = '0;
    bad = (sz == 0) || ((a % sz) != 0);
    if (sz != 0) begin
      for (int k = 0; k < 4; k++) begin
        wd[8*k +: 8] = d[8*(k % sz) +: 8];
        if (k >= lo && k < lo + sz) be[k] = 1'b1;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      logic bad;
      logic [31:0] wd;
      logic [3:0] be;
      bit do_push, do_pop;
      ent_t e;
      model_align(dm_ctrl, st_addr, st_data, bad, wd, be);
      do_push = st_valid && !bad && (q.size() != 4);
      do_pop  = (q.size() != 0) && mem_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.wa = st_addr[31:2];
        e.wd = wd;
        e.be = be;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic bad, hz;
      logic [31:0] wd;
      logic [3:0] be;
      model_align(dm_ctrl, st_addr, st_data, bad, wd, be);
      hz = 1'b0;
      foreach (q[k]) if (q[k].wa == ld_addr[31:2]) hz = 1'b1;
      chk("m_st_err",   32'(st_err),    32'(st_valid && bad));
      chk("m_st_ready", 32'(st_ready),  32'(q.size() != 4));
      chk("m_empty",    32'(empty),     32'(q.size() == 0));
      chk("m_mem_we",   32'(mem_we),    32'(q.size() != 0));
      chk("m_ld_hazard",32'(ld_hazard), 32'(ld_valid && hz));
      if (q.size() != 0) begin
        chk("m_mem_addr",  mem_addr,       {q[0].wa, 2'b00});
        chk("m_mem_wdata", mem_wdata,      q[0].wd);
        chk("m_mem_be",    32'(mem_be),    32'(q[0].be));
      end else begin
        chk("m_mem_addr0",  mem_addr,      32'h0);
        chk("m_mem_wdata0", mem_wdata,     32'h0);
        chk("m_mem_be0",    32'(mem_be),   32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] dm);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    dm_ctrl  = dm;
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_mem_we",   32'(mem_we),   32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_st_ready", 32'(st_ready), 32'h1);
    chk("rst_mem_addr", mem_addr,      32'h0);
    tick(); tick();
    rst = 1'b0;

    // Byte store
    mem_ready = 1'b1;
    st(1'b1, 32'h1003, 32'h0000_00A5, 3'd3);
    #1 chk("byte_err", 32'(st_err), 32'h0);
    tick();
    st(1'b0, 32'h0, 32'h0, 3'd0);
    chk("byte_we",    32'(mem_we),  32'h1);
    chk("byte_addr",  mem_addr,     32'h0000_1000);
    chk("byte_be",    32'(mem_be),  32'b1000);
    chk("byte_wdata", mem_wdata,    32'hA5A5_A5A5);
    tick();
    chk("byte_empty", 32'(empty), 32'h1);

    // Halfword store, then misaligned and illegal variants
    mem_ready = 1'b0;
    st(1'b1, 32'h2002, 32'h1234_BEEF, 3'd1);
    tick();
    st(1'b1, 32'h2001, 32'h1234_BEEF, 3'd1);
    chk("half_addr",  mem_addr,    32'h0000_2000);
    chk("half_be",    32'(mem_be), 32'b1100);
    chk("half_wdata", mem_wdata,   32'hBEEF_BEEF);
    #1 chk("half_misalign_err", 32'(st_err), 32'h1);
    tick();
    st(1'b1, 32'h2004, 32'h0, 3'd5);
    #1 chk("illegal_dm_err", 32'(st_err), 32'h1);
    tick();
    st(1'b0, 32'h0, 32'h0, 3'd0);
    mem_ready = 1'b1;
    tick();
    chk("half_single_entry", 32'(empty), 32'h1);

    // Backpressure and full
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st(1'b1, 32'(4 * i), 32'h1111_0000 + 32'(i), 3'd0);
      tick();
    end
    chk("full_ready", 32'(st_ready), 32'h0);
    st(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0);
    mem_ready = 1'b1;
    tick();
    st(1'b0, 32'h0, 32'h0, 3'd0);
    chk("drain_1", mem_addr, 32'h4);
    tick();
    chk("drain_2", mem_addr, 32'h8);
    tick();
    chk("drain_3", mem_addr, 32'hC);
    chk("drain_3_data", mem_wdata, 32'h1111_0003);
    tick();
    chk("fifth_refused", 32'(empty), 32'h1);

    // Hazard
    mem_ready = 1'b0;
    st(1'b1, 32'h40, 32'hCAFE_0040, 3'd0);
    tick();
    st(1'b0, 32'h0, 32'h0, 3'd0);
    ld_valid = 1'b1; ld_addr = 32'h43;
    #1 chk("haz_43", 32'(ld_hazard), 32'h1);
    ld_addr = 32'h44;
    #1 chk("haz_44", 32'(ld_hazard), 32'h0);
    ld_valid = 1'b0; ld_addr = 32'h40;
    #1 chk("haz_noval", 32'(ld_hazard), 32'h0);
    ld_valid = 1'b1; mem_ready = 1'b1;
    #1 chk("haz_popping", 32'(ld_hazard), 32'h1);
    tick();
    ld_valid = 1'b0;
    chk("haz_drained", 32'(empty), 32'h1);

    // Wrap-around with mixed sizes and interleaved mem_ready
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0: st(1'b1, 32'h100 + 32'(4 * i),     32'hA000_0000 + 32'(i), 3'd0);
        1: st(1'b1, 32'h100 + 32'(4 * i) + 2, 32'hB000_0000 + 32'(i), 3'd1);
        default: st(1'b1, 32'h100 + 32'(4 * i) + 3, 32'hC000_0000 + 32'(i), 3'd3);
      endcase
      mem_ready = (i % 3 != 0);
      tick();
    end
    st(1'b0, 32'h0, 32'h0, 3'd0);
    mem_ready = 1'b1;
    repeat (6) tick();
    chk("wrap_empty", 32'(empty), 32'h1);

    // Async reset mid-drain
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st(1'b1, 32'h300 + 32'(4 * i), 32'h3300_0000 + 32'(i), 3'd0);
      tick();
    end
    st(1'b0, 32'h0, 32'h0, 3'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_we",    32'(mem_we), 32'h0);
    chk("arst_empty", 32'(empty),  32'h1);
    chk("arst_be",    32'(mem_be), 32'h0);
    tick();
    rst = 1'b0;
    st(1'b1, 32'h500, 32'h5555_AAAA, 3'd0);
    tick();
    st(1'b0, 32'h0, 32'h0, 3'd0);
    chk("post_rst_we",   32'(mem_we), 32'h1);
    chk("post_rst_addr", mem_addr,    32'h500);
    mem_ready = 1'b1;
    tick(); tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
